// File: rtl/cam_emulator.sv
// OV7670-style camera source: pclk = clk/2 while busy, href/vsync framing and
// RGB444 test patterns sent as two bytes per pixel, all updated on pclk falls.
module cam_emulator #(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int H_BLANK = 16,
    parameter int V_SYNC  = 3,
    parameter int V_BACK  = 2,
    parameter int V_FRONT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_color,
    output logic        CAM_pclk,
    output logic        CAM_href,
    output logic        CAM_vsync,
    output logic [7:0]  CAM_px_data,
    output logic        frame_done,
    output logic        busy
);
    localparam int LINE_T = 2 * H_PIX + H_BLANK;
    localparam int BAR_W  = H_PIX / 8;
    localparam int CW_RAW = $clog2((V_SYNC + V_BACK + V_FRONT) * LINE_T + 1);
    localparam int CW     = (CW_RAW > 5) ? CW_RAW : 5;
    localparam int LW_RAW = $clog2(V_LINES + 1);
    localparam int LW     = (LW_RAW > 4) ? LW_RAW : 4;
    localparam int BW     = $clog2(BAR_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_HBLANK = 3'd4;
    localparam logic [2:0] S_VFRONT = 3'd5;

    localparam logic [CW-1:0] VS_LAST   = CW'(V_SYNC * LINE_T - 1);
    localparam logic [CW-1:0] VB_LAST   = CW'(V_BACK * LINE_T - 1);
    localparam logic [CW-1:0] VF_LAST   = CW'(V_FRONT * LINE_T - 1);
    localparam logic [CW-1:0] ACT_LAST  = CW'(2 * H_PIX - 1);
    localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);
    localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_W - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [11:0]   pix_q, pix_d;
    logic [1:0]    pat_q, pat_d;
    logic [11:0]   solid_q, solid_d;
    logic          pclk_q, pclk_d;
    logic          busy_q, busy_d;
    logic          href_q, href_d;
    logic          vsync_q, vsync_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          tick, start;
    logic [11:0]   rgb;

    always_comb begin
        // NOTE: every _d gets a default up front so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        pix_d     = pix_q;
        pat_d     = pat_q;
        solid_d   = solid_q;
        busy_d    = busy_q;
        href_d    = href_q;
        vsync_d   = vsync_q;
        data_d    = data_q;
        done_d    = 1'b0;
        pclk_d    = busy_q ? ~pclk_q : 1'b0;
        tick      = busy_q & pclk_q;
        start     = 1'b0;
        rgb       = 12'h000;

        if (state_q == S_IDLE) begin
            start = enable;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                S_VSYNC: if (cnt_q == VS_LAST) begin state_d = S_VBACK; cnt_d = '0; end
                S_VBACK: if (cnt_q == VB_LAST) begin state_d = S_ACTIVE; cnt_d = '0; end
                S_ACTIVE: if (cnt_q == ACT_LAST) begin state_d = S_HBLANK; cnt_d = '0; end
                S_HBLANK: if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (line_q == LINE_LAST) begin
                        state_d = S_VFRONT;
                    end else begin
                        line_d  = line_q + 1'b1;
                        state_d = S_ACTIVE;
                    end
                end
                S_VFRONT: if (cnt_q == VF_LAST) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: begin state_d = S_IDLE; busy_d = 1'b0; end
            endcase
        end

        // Frame boundary: inputs are captured here and nowhere else.
        if (start) begin
            state_d   = S_VSYNC;
            busy_d    = 1'b1;
            pat_d     = pattern_sel;
            solid_d   = solid_color;
            cnt_d     = '0;
            line_d    = '0;
            pix_d     = '0;
            bar_idx_d = '0;
            bar_cnt_d = '0;
        end

        case (pat_q)
            2'd0: begin
                case (bar_idx_q)
                    3'd0: rgb = 12'hFFF;
                    3'd1: rgb = 12'hFF0;
                    3'd2: rgb = 12'h0FF;
                    3'd3: rgb = 12'h0F0;
                    3'd4: rgb = 12'hF0F;
                    3'd5: rgb = 12'hF00;
                    3'd6: rgb = 12'h00F;
                    default: rgb = 12'h000;
                endcase
            end
            2'd1: rgb = pix_q;
            2'd2: rgb = solid_q;
            default: rgb = (cnt_d[4] ^ line_d[3]) ? 12'hFFF : 12'h000;
        endcase

        // Outputs are registered from the next position so they change with the tick.
        if (tick || start) begin
            href_d  = (state_d == S_ACTIVE);
            vsync_d = (state_d == S_VSYNC);
            data_d  = 8'h00;
            if (state_d == S_ACTIVE) begin
                data_d = cnt_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
                // Pixel trackers step after the second byte of each pixel.
                if (cnt_d[0]) begin
                    pix_d = pix_q + 12'd1;
                    if (bar_cnt_q == BAR_LAST) begin
                        bar_cnt_d = '0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_cnt_d = bar_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            line_q    <= '0;
            bar_idx_q <= '0;
            bar_cnt_q <= '0;
            pix_q     <= '0;
            pat_q     <= '0;
            solid_q   <= '0;
            pclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            href_q    <= 1'b0;
            vsync_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            bar_idx_q <= bar_idx_d;
            bar_cnt_q <= bar_cnt_d;
            pix_q     <= pix_d;
            pat_q     <= pat_d;
            solid_q   <= solid_d;
            pclk_q    <= pclk_d;
            busy_q    <= busy_d;
            href_q    <= href_d;
            vsync_q   <= vsync_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    assign CAM_pclk    = pclk_q;
    assign CAM_href    = href_q;
    assign CAM_vsync   = vsync_q;
    assign CAM_px_data = data_q;
    assign frame_done  = done_q;
    assign busy        = busy_q;
endmodule
